// File: rtl/fire_alert_controller.sv
// Fire-alert sequencing controller: synchronises the FFT and camera flags, confirms
// sustained agreement, latches the alarm until a clear-condition ack, then cools down.
module fire_alert_controller #(
    parameter int CONFIRM_CYCLES  = 16,
    parameter int CLEAR_CYCLES    = 64,
    parameter int COOLDOWN_CYCLES = 256,
    parameter int MISMATCH_CYCLES = 128,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       fft_flag,
    input  logic       cam_flag,
    input  logic       ack,
    output logic       final_alert,
    output logic [1:0] state_o,
    output logic       ack_rejected,
    output logic       mismatch,
    output logic [7:0] alarm_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_ALARM    = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_MAX    = CNT_W'(CLEAR_CYCLES);
    localparam logic [CNT_W-1:0] COOL_LAST    = CNT_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIS_MAX      = CNT_W'(MISMATCH_CYCLES);

    logic             fft_meta_r, fft_sync_r, cam_meta_r, cam_sync_r;
    logic             both_s, none_s, one_s, clear_ok_s;
    state_t           state_r, state_nxt_s;
    logic [CNT_W-1:0] confirm_r, confirm_nxt_s;
    logic [CNT_W-1:0] clear_r, clear_nxt_s;
    logic [CNT_W-1:0] cool_r, cool_nxt_s;
    logic [CNT_W-1:0] mis_r, mis_nxt_s;
    logic             reject_nxt_s, alarm_entry_s;
    logic             final_alert_r, ack_rejected_r, mismatch_r;
    logic [7:0]       alarm_count_r;

    assign both_s     = fft_sync_r & cam_sync_r;
    assign none_s     = ~fft_sync_r & ~cam_sync_r;
    assign one_s      = fft_sync_r ^ cam_sync_r;
    assign clear_ok_s = (clear_r == CLEAR_MAX);

    // Two-flop synchronisers for the asynchronous sensor flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fft_meta_r <= 1'b0;
            fft_sync_r <= 1'b0;
            cam_meta_r <= 1'b0;
            cam_sync_r <= 1'b0;
        end else begin
            fft_meta_r <= fft_flag;
            fft_sync_r <= fft_meta_r;
            cam_meta_r <= cam_flag;
            cam_sync_r <= cam_meta_r;
        end
    end

    // Next-state and counter logic for the alert sequencer
    always_comb begin
        state_nxt_s   = state_r;
        confirm_nxt_s = confirm_r;
        clear_nxt_s   = clear_r;
        cool_nxt_s    = cool_r;
        reject_nxt_s  = 1'b0;
        alarm_entry_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                confirm_nxt_s = CNT_ZERO;
                clear_nxt_s   = CNT_ZERO;
                cool_nxt_s    = CNT_ZERO;
                if (both_s) begin
                    state_nxt_s = ST_PENDING;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PENDING: begin
                if (!both_s) begin
                    state_nxt_s   = ST_IDLE;
                    confirm_nxt_s = CNT_ZERO;
                end else if (confirm_r == CONFIRM_LAST) begin
                    state_nxt_s   = ST_ALARM;
                    confirm_nxt_s = CNT_ZERO;
                    clear_nxt_s   = CNT_ZERO;
                    alarm_entry_s = 1'b1;
                end else begin
                    confirm_nxt_s = confirm_r + CNT_ONE;
                end
            end
            ST_ALARM: begin
                // Clear run saturates so a long quiet period keeps clear_ok asserted
                if (!none_s) begin
                    clear_nxt_s = CNT_ZERO;
                end else if (clear_r != CLEAR_MAX) begin
                    clear_nxt_s = clear_r + CNT_ONE;
                end else begin
                    clear_nxt_s = clear_r;
                end
                if (ack && clear_ok_s) begin
                    state_nxt_s = ST_COOLDOWN;
                    cool_nxt_s  = CNT_ZERO;
                end else if (ack) begin
                    reject_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_ALARM;
                end
            end
            ST_COOLDOWN: begin
                if (cool_r == COOL_LAST) begin
                    state_nxt_s = ST_IDLE;
                    cool_nxt_s  = CNT_ZERO;
                end else begin
                    cool_nxt_s = cool_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Disagreement run length, independent of the sequencer
    always_comb begin
        mis_nxt_s = CNT_ZERO;
        if (!one_s) begin
            mis_nxt_s = CNT_ZERO;
        end else if (mis_r != MIS_MAX) begin
            mis_nxt_s = mis_r + CNT_ONE;
        end else begin
            mis_nxt_s = mis_r;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            confirm_r      <= CNT_ZERO;
            clear_r        <= CNT_ZERO;
            cool_r         <= CNT_ZERO;
            mis_r          <= CNT_ZERO;
            final_alert_r  <= 1'b0;
            ack_rejected_r <= 1'b0;
            mismatch_r     <= 1'b0;
            alarm_count_r  <= 8'd0;
        end else begin
            state_r        <= state_nxt_s;
            confirm_r      <= confirm_nxt_s;
            clear_r        <= clear_nxt_s;
            cool_r         <= cool_nxt_s;
            mis_r          <= mis_nxt_s;
            final_alert_r  <= (state_nxt_s == ST_ALARM);
            ack_rejected_r <= reject_nxt_s;
            mismatch_r     <= (mis_nxt_s >= MIS_MAX);
            if (alarm_entry_s && (alarm_count_r != 8'hFF)) begin
                alarm_count_r <= alarm_count_r + 8'd1;
            end else begin
                alarm_count_r <= alarm_count_r;
            end
        end
    end

    assign final_alert  = final_alert_r;
    assign state_o      = state_r;
    assign ack_rejected = ack_rejected_r;
    assign mismatch     = mismatch_r;
    assign alarm_count  = alarm_count_r;

endmodule

// File: tb/tb_fire_alert_controller.sv
// Bench for fire_alert_controller: a default-parameter and a small-parameter instance
// share stimulus; a timestamp-based reference model checks both every cycle.
module tb_fire_alert_controller;

    localparam int KC_D = 16, KL_D = 64, KD_D = 256, KM_D = 128;
    localparam int KC_S = 3,  KL_S = 4,  KD_S = 5,   KM_S = 6;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       fft_flag = 1'b0, cam_flag = 1'b0, ack = 1'b0;
    logic       d_fa, d_rej, d_mm, s_fa, s_rej, s_mm;
    logic [1:0] d_st, s_st;
    logic [7:0] d_ac, s_ac;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    fire_alert_controller dut (
        .clk(clk), .reset_n(reset_n), .fft_flag(fft_flag), .cam_flag(cam_flag), .ack(ack),
        .final_alert(d_fa), .state_o(d_st), .ack_rejected(d_rej), .mismatch(d_mm),
        .alarm_count(d_ac)
    );

    fire_alert_controller #(
        .CONFIRM_CYCLES(KC_S), .CLEAR_CYCLES(KL_S), .COOLDOWN_CYCLES(KD_S),
        .MISMATCH_CYCLES(KM_S), .CNT_W(4)
    ) dut_s (
        .clk(clk), .reset_n(reset_n), .fft_flag(fft_flag), .cam_flag(cam_flag), .ack(ack),
        .final_alert(s_fa), .state_o(s_st), .ack_rejected(s_rej), .mismatch(s_mm),
        .alarm_count(s_ac)
    );

    always #5 clk = ~clk;

    // Model: mode 0..3, entry timestamp, run lengths, and the flag seen 1 and 2 edges ago
    typedef struct {
        int mode;
        int t_enter;
        int none_run;
        int one_run;
        int alarms;
        bit rej;
        bit h1f, h1c, h2f, h2c;
    } mdl_t;

    mdl_t md, ms;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int n, input int kc, input int kl,
                                  input int kd, input bit f, input bit c, input bit a);
        mdl_t r;
        bit both, none, one;
        r    = m;
        both = m.h2f && m.h2c;
        none = !m.h2f && !m.h2c;
        one  = m.h2f != m.h2c;
        r.h2f = m.h1f; r.h2c = m.h1c; r.h1f = f; r.h1c = c;
        r.rej = 0;
        case (m.mode)
            0: if (both) begin r.mode = 1; r.t_enter = n; end
            1: begin
                if (!both) r.mode = 0;
                else if (n - m.t_enter == kc) begin
                    r.mode = 2;
                    r.none_run = 0;
                    if (m.alarms < 255) r.alarms = m.alarms + 1;
                end
            end
            2: begin
                if (a && m.none_run >= kl) begin r.mode = 3; r.t_enter = n; end
                else if (a) r.rej = 1;
                r.none_run = none ? m.none_run + 1 : 0;
            end
            3: if (n - m.t_enter == kd) r.mode = 0;
            default: r.mode = 0;
        endcase
        r.one_run = one ? m.one_run + 1 : 0;
        return r;
    endfunction

    task automatic check_out(input string nm, input logic [1:0] st, input logic fa,
                             input logic rej, input logic mm, input logic [7:0] ac,
                             input logic [1:0] est, input logic efa, input logic erej,
                             input logic emm, input logic [7:0] eac);
        tests++;
        if ({st, fa, rej, mm, ac} !== {est, efa, erej, emm, eac}) begin
            fails++;
            $display("FAIL %s cyc=%0d: got st=%0d fa=%0b rej=%0b mm=%0b ac=%0d, want st=%0d fa=%0b rej=%0b mm=%0b ac=%0d",
                     nm, cyc, st, fa, rej, mm, ac, est, efa, erej, emm, eac);
        end
    endtask

    task automatic check_models();
        logic [1:0] e_st;
        e_st = md.mode[1:0];
        check_out("model_dflt", d_st, d_fa, d_rej, d_mm, d_ac, e_st, md.mode == 2, md.rej,
                  md.one_run >= KM_D, md.alarms[7:0]);
        e_st = ms.mode[1:0];
        check_out("model_small", s_st, s_fa, s_rej, s_mm, s_ac, e_st, ms.mode == 2, ms.rej,
                  ms.one_run >= KM_S, ms.alarms[7:0]);
    endtask

    task automatic tick();
        cyc++;
        md = step(md, cyc, KC_D, KL_D, KD_D, fft_flag, cam_flag, ack);
        ms = step(ms, cyc, KC_S, KL_S, KD_S, fft_flag, cam_flag, ack);
        @(posedge clk);
        #1;
        check_models();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input string nm);
        reset_n = 1'b0;
        #1;
        md = mdl_reset();
        ms = mdl_reset();
        check_out({nm, "_dflt"}, d_st, d_fa, d_rej, d_mm, d_ac, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_out({nm, "_small"}, s_st, s_fa, s_rej, s_mm, s_ac, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic set_in(input bit f, input bit c, input bit a);
        fft_flag = f;
        cam_flag = c;
        ack      = a;
    endtask

    typedef struct {
        bit         f;
        bit         c;
        bit         a;
        int         n;
        logic [1:0] st;
        bit         fa;
        bit         rej;
        bit         mm;
        logic [7:0] ac;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int mode;
        // Expected default-instance outputs after each row's cycles
        tbl.push_back('{1, 1, 0, 10,  2'd1, 0, 0, 0, 8'd0});  // pending
        tbl.push_back('{1, 0, 0, 3,   2'd0, 0, 0, 0, 8'd0});  // cam drop aborts
        tbl.push_back('{0, 0, 0, 5,   2'd0, 0, 0, 0, 8'd0});
        tbl.push_back('{1, 1, 0, 18,  2'd1, 0, 0, 0, 8'd0});  // one edge short
        tbl.push_back('{1, 1, 0, 1,   2'd2, 1, 0, 0, 8'd1});  // alarm on edge 19
        tbl.push_back('{0, 0, 0, 30,  2'd2, 1, 0, 0, 8'd1});  // latched
        tbl.push_back('{0, 0, 1, 1,   2'd2, 1, 1, 0, 8'd1});  // early ack rejected
        tbl.push_back('{0, 0, 0, 70,  2'd2, 1, 0, 0, 8'd1});
        tbl.push_back('{0, 0, 1, 1,   2'd3, 0, 0, 0, 8'd1});  // accepted ack
        tbl.push_back('{0, 0, 0, 255, 2'd3, 0, 0, 0, 8'd1});
        tbl.push_back('{0, 0, 0, 1,   2'd0, 0, 0, 0, 8'd1});  // idle 256 later
        tbl.push_back('{0, 0, 1, 1,   2'd0, 0, 0, 0, 8'd1});  // ack in idle ignored
        tbl.push_back('{1, 1, 0, 19,  2'd2, 1, 0, 0, 8'd2});
        tbl.push_back('{1, 1, 1, 1,   2'd2, 1, 1, 0, 8'd2});  // flags high: reject
        tbl.push_back('{1, 1, 0, 100, 2'd2, 1, 0, 0, 8'd2});
        tbl.push_back('{1, 1, 1, 1,   2'd2, 1, 1, 0, 8'd2});

        md = mdl_reset();
        ms = mdl_reset();
        #1;
        do_reset("reset_init");

        for (int i = 0; i < tbl.size(); i++) begin
            set_in(tbl[i].f, tbl[i].c, tbl[i].a);
            ticks(tbl[i].n);
            check_out($sformatf("vec%0d", i), d_st, d_fa, d_rej, d_mm, d_ac,
                      tbl[i].st, tbl[i].fa, tbl[i].rej, tbl[i].mm, tbl[i].ac);
        end
        set_in(1'b1, 1'b1, 1'b0);
        do_reset("reset_alarm");

        // Sustained disagreement raises mismatch; agreement clears it and starts PENDING
        set_in(1'b1, 1'b0, 1'b0);
        ticks(129);
        check_out("mm_before", d_st, d_fa, d_rej, d_mm, d_ac, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        check_out("mm_set", d_st, d_fa, d_rej, d_mm, d_ac, 2'd0, 1'b0, 1'b0, 1'b1, 8'd0);
        set_in(1'b1, 1'b1, 1'b0);
        ticks(2);
        check_out("mm_hold", d_st, d_fa, d_rej, d_mm, d_ac, 2'd0, 1'b0, 1'b0, 1'b1, 8'd0);
        tick();
        check_out("mm_clear", d_st, d_fa, d_rej, d_mm, d_ac, 2'd1, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        do_reset("reset_pending");

        set_in(1'b1, 1'b1, 1'b0);
        ticks(19);
        set_in(1'b0, 1'b0, 1'b0);
        ticks(70);
        set_in(1'b0, 1'b0, 1'b1);
        tick();
        set_in(1'b0, 1'b0, 1'b0);
        ticks(10);
        check_out("cooldown", d_st, d_fa, d_rej, d_mm, d_ac, 2'd3, 1'b0, 1'b0, 1'b0, 8'd1);
        do_reset("reset_cooldown");

        // 257 alarms on the small instance saturate its counter
        for (int k = 0; k < 257; k++) begin
            set_in(1'b1, 1'b1, 1'b0);
            ticks(8);
            set_in(1'b0, 1'b0, 1'b0);
            ticks(10);
            set_in(1'b0, 1'b0, 1'b1);
            tick();
            set_in(1'b0, 1'b0, 1'b0);
            ticks(8);
        end
        check_out("saturate", s_st, s_fa, s_rej, s_mm, s_ac, 2'd0, 1'b0, 1'b0, 1'b0, 8'd255);
        do_reset("reset_rand");

        mode = 0;
        for (int i = 0; i < 6000; i++) begin
            if (i % 80 == 0) mode = $urandom_range(0, 3);
            case (mode)
                0: begin fft_flag = 1'b1; cam_flag = 1'b1; end
                1: begin fft_flag = 1'b0; cam_flag = 1'b0; end
                default: begin
                    if ($urandom_range(0, 3) == 0) fft_flag = ~fft_flag;
                    if ($urandom_range(0, 3) == 0) cam_flag = ~cam_flag;
                end
            endcase
            ack = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 999) == 0) do_reset("reset_rnd");
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
